// File: rtl/pal_hd_pkg.sv
// Shared constants and helpers for the PAL-to-HD line buffer.
// Bank base addresses are computed here so the scheduler and the datapath agree.
package pal_hd_pkg;

   localparam int NUM_BANKS   = 4;
   localparam int BANK_ADDR_W = 11;
   localparam int PTR_W       = $clog2(NUM_BANKS);

   // Start address of bank 'ptr', offset into the line by 'offset'.
   function automatic logic [31:0] bank_base(input logic [31:0] ptr,
                                             input logic [31:0] offset,
                                             input int addr_w = BANK_ADDR_W);
      return (ptr << addr_w) + offset;
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one sync input and flags its rising and falling edges.
// The previous value resets high so an idle (high) sync line gives no edge.
module sync_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic sync_in,
   output logic rise,
   output logic fall
);

   logic prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         prev <= 1'b1;
      end else begin
         prev <= sync_in;
      end
   end

   assign rise = sync_in & ~prev;
   assign fall = ~sync_in & prev;

endmodule

// File: rtl/pal_line_bank_scheduler.sv
// Chooses the PAL write bank and HD read bank of the line buffer, tracks queued
// lines, drops PAL lines on overrun, repeats HD lines on underrun, resyncs per frame.
module pal_line_bank_scheduler
   import pal_hd_pkg::*;
#(
   parameter int NUM_BANKS   = pal_hd_pkg::NUM_BANKS,
   parameter int BANK_ADDR_W = pal_hd_pkg::BANK_ADDR_W,
   parameter int ADDR_W      = 13,
   parameter int OFFSET_HZ   = 60
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_pal_hsync,
   input  logic                         i_pal_vsync,
   input  logic                         i_hd_hsync,
   input  logic                         i_hd_vsync,
   output logic [ADDR_W-1:0]            o_wr_base,
   output logic                         o_wr_line_start,
   output logic [ADDR_W-1:0]            o_rd_base,
   output logic                         o_rd_line_start,
   output logic [$clog2(NUM_BANKS)-1:0] o_fill,
   output logic                         o_overrun,
   output logic                         o_underrun,
   output logic                         o_frame_end
);

   localparam int PTR_W = $clog2(NUM_BANKS);
   localparam logic [PTR_W-1:0] ONE      = PTR_W'(1);
   localparam logic [PTR_W-1:0] FILL_MAX = PTR_W'(NUM_BANKS - 2);

   logic pal_hs_rise, pal_hs_fall, pal_vs_fall, hd_hs_rise, hd_vs_fall;
   logic pal_vs_rise_unused, hd_hs_fall_unused, hd_vs_rise_unused;

   logic [PTR_W-1:0] wr_ptr, rd_ptr, fill;
   logic [PTR_W-1:0] wr_next, rd_next, fill_next;
   logic             resync_pending, pending_next;
   logic             resync, commit_ok, consume_ok, overrun_next, underrun_next;

   sync_edge_detect u_pal_hs (.clk(clk), .rst(rst), .sync_in(i_pal_hsync),
                              .rise(pal_hs_rise), .fall(pal_hs_fall));
   sync_edge_detect u_pal_vs (.clk(clk), .rst(rst), .sync_in(i_pal_vsync),
                              .rise(pal_vs_rise_unused), .fall(pal_vs_fall));
   sync_edge_detect u_hd_hs  (.clk(clk), .rst(rst), .sync_in(i_hd_hsync),
                              .rise(hd_hs_rise), .fall(hd_hs_fall_unused));
   sync_edge_detect u_hd_vs  (.clk(clk), .rst(rst), .sync_in(i_hd_vsync),
                              .rise(hd_vs_rise_unused), .fall(hd_vs_fall));

   assign resync     = hd_vs_fall & resync_pending;
   assign commit_ok  = pal_hs_rise & (fill < FILL_MAX);
   assign consume_ok = hd_hs_rise & (fill != '0);

   // Commit and consume both judge the pre-cycle fill; a resync overrides them.
   always_comb begin
      wr_next       = wr_ptr;
      rd_next       = rd_ptr;
      fill_next     = fill;
      pending_next  = resync_pending;
      overrun_next  = 1'b0;
      underrun_next = 1'b0;
      if (resync) begin
         fill_next    = '0;
         pending_next = 1'b0;
         if (pal_hs_rise) begin
            rd_next = wr_ptr;
            wr_next = wr_ptr + ONE;
         end else begin
            rd_next = wr_ptr - ONE;
         end
      end else begin
         wr_next       = wr_ptr + PTR_W'(commit_ok);
         rd_next       = rd_ptr + PTR_W'(consume_ok);
         fill_next     = fill + PTR_W'(commit_ok) - PTR_W'(consume_ok);
         overrun_next  = pal_hs_rise & ~commit_ok;
         underrun_next = hd_hs_rise & ~consume_ok;
      end
      if (pal_vs_fall) begin
         pending_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr          <= ONE;
         rd_ptr          <= '0;
         fill            <= '0;
         resync_pending  <= 1'b0;
         o_wr_base       <= ADDR_W'(bank_base(32'd1, 32'd0, BANK_ADDR_W));
         o_rd_base       <= ADDR_W'(bank_base(32'd0, 32'(OFFSET_HZ), BANK_ADDR_W));
         o_wr_line_start <= 1'b0;
         o_rd_line_start <= 1'b0;
         o_overrun       <= 1'b0;
         o_underrun      <= 1'b0;
         o_frame_end     <= 1'b0;
      end else begin
         wr_ptr          <= wr_next;
         rd_ptr          <= rd_next;
         fill            <= fill_next;
         resync_pending  <= pending_next;
         o_wr_line_start <= pal_hs_fall;
         o_rd_line_start <= hd_hs_rise;
         o_overrun       <= overrun_next;
         o_underrun      <= underrun_next;
         o_frame_end     <= pal_vs_fall;
         if (pal_hs_fall) begin
            o_wr_base <= ADDR_W'(bank_base(32'(wr_ptr), 32'd0, BANK_ADDR_W));
         end
         if (hd_hs_rise) begin
            o_rd_base <= ADDR_W'(bank_base(32'(rd_next), 32'(OFFSET_HZ), BANK_ADDR_W));
         end
      end
   end

   assign o_fill = fill;

endmodule

// File: tb/tb_pal_line_bank_scheduler.sv
// Scoreboard bench for pal_line_bank_scheduler: stimulus pushes hand-computed
// expectations, a negedge monitor pops one per output pulse (or quiet check).
module tb_pal_line_bank_scheduler;

   localparam logic [4:0] P_NONE = 5'b00000;
   localparam logic [4:0] P_WLS  = 5'b10000;
   localparam logic [4:0] P_RLS  = 5'b01000;
   localparam logic [4:0] P_OVR  = 5'b00100;
   localparam logic [4:0] P_UND  = 5'b00010;
   localparam logic [4:0] P_FE   = 5'b00001;

   typedef struct packed {
      logic [4:0]  pulses;
      logic [12:0] wr_base;
      logic [12:0] rd_base;
      logic [1:0]  fill;
   } obs_t;

   typedef struct packed {
      logic quiet;
      obs_t obs;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pal_hs = 1'b1;
   logic        pal_vs = 1'b1;
   logic        hd_hs = 1'b0;
   logic        hd_vs = 1'b1;
   logic [12:0] wr_base, rd_base;
   logic        wr_line_start, rd_line_start, overrun, underrun, frame_end;
   logic [1:0]  fill;

   obs_t actual;
   rec_t exp_q[$];
   rec_t mon_rec;
   logic done = 1'b0;
   int   compared = 0;
   int   mismatched = 0;

   pal_line_bank_scheduler dut (
      .clk(clk), .rst(rst),
      .i_pal_hsync(pal_hs), .i_pal_vsync(pal_vs),
      .i_hd_hsync(hd_hs), .i_hd_vsync(hd_vs),
      .o_wr_base(wr_base), .o_wr_line_start(wr_line_start),
      .o_rd_base(rd_base), .o_rd_line_start(rd_line_start),
      .o_fill(fill), .o_overrun(overrun), .o_underrun(underrun),
      .o_frame_end(frame_end)
   );

   always #5 clk = ~clk;

   assign actual = {wr_line_start, rd_line_start, overrun, underrun, frame_end,
                    wr_base, rd_base, fill};

   function automatic void check_output(input obs_t got, input obs_t want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("[TB] FAIL chk%0d: got pulses=%b wr_base=%h rd_base=%h fill=%0d, required pulses=%b wr_base=%h rd_base=%h fill=%0d",
                  compared, got.pulses, got.wr_base, got.rd_base, got.fill,
                  want.pulses, want.wr_base, want.rd_base, want.fill);
      end
   endfunction

   // Pulses pop event records; quiet records are checked on a pulse-free cycle.
   always @(negedge clk) begin
      if (done) begin
         compared++;
         if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL leftover: %0d expected events never seen, required 0", exp_q.size());
         end
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
         $finish;
      end else if (!rst) begin
         if (exp_q.size() > 0 && (actual.pulses != P_NONE || exp_q[0].quiet)) begin
            mon_rec = exp_q.pop_front();
            check_output(actual, mon_rec.obs);
         end else if (actual.pulses != P_NONE) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_pulse: got pulses=%b, required none", actual.pulses);
         end
      end
   end

   function automatic void push_exp(input logic quiet, input logic [4:0] p,
                                    input logic [12:0] wb, input logic [12:0] rb,
                                    input logic [1:0] f);
      rec_t r;
      r.quiet       = quiet;
      r.obs.pulses  = p;
      r.obs.wr_base = wb;
      r.obs.rd_base = rb;
      r.obs.fill    = f;
      exp_q.push_back(r);
   endfunction

   task automatic apply_stimulus(input logic ph, input logic pv, input logic hh, input logic hv);
      @(negedge clk);
      pal_hs = ph;
      pal_vs = pv;
      hd_hs  = hh;
      hd_vs  = hv;
      repeat (3) @(negedge clk);
   endtask

   task automatic pal_level(input logic ph);
      apply_stimulus(ph, pal_vs, hd_hs, hd_vs);
   endtask

   task automatic hd_line();
      apply_stimulus(pal_hs, pal_vs, 1'b1, hd_vs);
      apply_stimulus(pal_hs, pal_vs, 1'b0, hd_vs);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: bench did not reach its summary");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      push_exp(1, P_NONE, 13'h0800, 13'h003C, 0);
      repeat (2) @(negedge clk);

      // Steady state: three PAL lines (third overruns), then three HD lines.
      push_exp(0, P_WLS, 13'h0800, 13'h003C, 0); pal_level(0); pal_level(1);
      push_exp(1, P_NONE, 13'h0800, 13'h003C, 1);
      push_exp(0, P_WLS, 13'h1000, 13'h003C, 1); pal_level(0); pal_level(1);
      push_exp(0, P_WLS, 13'h1800, 13'h003C, 2); pal_level(0);
      push_exp(0, P_OVR, 13'h1800, 13'h003C, 2); pal_level(1);
      push_exp(0, P_RLS, 13'h1800, 13'h083C, 1); hd_line();
      push_exp(0, P_RLS, 13'h1800, 13'h103C, 0); hd_line();
      push_exp(0, P_RLS | P_UND, 13'h1800, 13'h103C, 0); hd_line();

      // Overrun with write pointer wrapping 3 -> 0; the dropped line reuses bank 1.
      push_exp(0, P_WLS, 13'h1800, 13'h103C, 0); pal_level(0); pal_level(1);
      push_exp(0, P_WLS, 13'h0000, 13'h103C, 1); pal_level(0); pal_level(1);
      push_exp(0, P_WLS, 13'h0800, 13'h103C, 2); pal_level(0);
      push_exp(0, P_OVR, 13'h0800, 13'h103C, 2); pal_level(1);
      push_exp(0, P_WLS, 13'h0800, 13'h103C, 2); pal_level(0);
      push_exp(0, P_OVR, 13'h0800, 13'h103C, 2); pal_level(1);

      // Alternating HD/PAL lines, both pointers wrap, no over/underrun.
      push_exp(0, P_RLS, 13'h0800, 13'h183C, 1); hd_line();
      push_exp(0, P_WLS, 13'h0800, 13'h183C, 1); pal_level(0); pal_level(1);
      push_exp(0, P_RLS, 13'h0800, 13'h003C, 1); hd_line();
      push_exp(0, P_WLS, 13'h1000, 13'h003C, 1); pal_level(0); pal_level(1);
      push_exp(0, P_RLS, 13'h1000, 13'h083C, 1); hd_line();
      push_exp(0, P_WLS, 13'h1800, 13'h083C, 1); pal_level(0); pal_level(1);
      push_exp(0, P_RLS, 13'h1800, 13'h103C, 1); hd_line();
      push_exp(0, P_WLS, 13'h0000, 13'h103C, 1); pal_level(0); pal_level(1);
      push_exp(0, P_RLS, 13'h0000, 13'h183C, 1); hd_line();
      push_exp(0, P_RLS, 13'h0000, 13'h003C, 0); hd_line();

      // Same-cycle commit and consume at fill=0 and at fill=2.
      push_exp(0, P_WLS, 13'h0800, 13'h003C, 0); pal_level(0);
      push_exp(0, P_RLS | P_UND, 13'h0800, 13'h003C, 1);
      apply_stimulus(1, 1, 1, 1);
      apply_stimulus(1, 1, 0, 1);
      push_exp(0, P_WLS, 13'h1000, 13'h003C, 1); pal_level(0); pal_level(1);
      push_exp(1, P_NONE, 13'h1000, 13'h003C, 2);
      push_exp(0, P_WLS, 13'h1800, 13'h003C, 2); pal_level(0);
      push_exp(0, P_OVR | P_RLS, 13'h1800, 13'h083C, 1);
      apply_stimulus(1, 1, 1, 1);
      apply_stimulus(1, 1, 0, 1);

      // Frame resync: rd_ptr lands on wr_ptr-1 and the next HD line underruns.
      push_exp(0, P_FE, 13'h1800, 13'h083C, 1); apply_stimulus(1, 0, 0, 1);
      apply_stimulus(1, 0, 0, 0);
      push_exp(1, P_NONE, 13'h1800, 13'h083C, 0);
      push_exp(0, P_RLS | P_UND, 13'h1800, 13'h103C, 0); hd_line();
      apply_stimulus(1, 1, 0, 1);

      // Resync coinciding with a commit and a consume.
      push_exp(0, P_WLS, 13'h1800, 13'h103C, 0); pal_level(0);
      push_exp(0, P_FE, 13'h1800, 13'h103C, 0); apply_stimulus(0, 0, 0, 1);
      push_exp(0, P_RLS, 13'h1800, 13'h183C, 0); apply_stimulus(1, 0, 1, 0);
      apply_stimulus(1, 1, 0, 1);
      push_exp(0, P_WLS, 13'h0000, 13'h183C, 0); pal_level(0); pal_level(1);

      // Two PAL vsync falls before one HD vsync fall resync only once.
      push_exp(0, P_FE, 13'h0000, 13'h183C, 1); apply_stimulus(1, 0, 0, 1);
      apply_stimulus(1, 1, 0, 1);
      push_exp(0, P_FE, 13'h0000, 13'h183C, 1); apply_stimulus(1, 0, 0, 1);
      apply_stimulus(1, 1, 0, 1);
      apply_stimulus(1, 1, 0, 0);
      push_exp(1, P_NONE, 13'h0000, 13'h183C, 0);
      apply_stimulus(1, 1, 0, 1);
      push_exp(0, P_RLS | P_UND, 13'h0000, 13'h003C, 0); hd_line();

      // Reset mid-line overrides a same-cycle commit and consume.
      push_exp(0, P_WLS, 13'h0800, 13'h003C, 0); pal_level(0); pal_level(1);
      push_exp(0, P_WLS, 13'h1000, 13'h003C, 1); pal_level(0);
      @(negedge clk);
      rst    = 1'b1;
      pal_hs = 1'b1;
      hd_hs  = 1'b1;
      repeat (2) @(negedge clk);
      rst   = 1'b0;
      hd_hs = 1'b0;
      push_exp(1, P_NONE, 13'h0800, 13'h003C, 0);
      repeat (3) @(negedge clk);
      push_exp(0, P_WLS, 13'h0800, 13'h003C, 0); pal_level(0); pal_level(1);
      push_exp(1, P_NONE, 13'h0800, 13'h003C, 1);
      repeat (4) @(negedge clk);

      done = 1'b1;
   end

endmodule
